// File: rtl/proc_debug_ctrl_pkg.sv
`default_nettype none
// proc_dbg_pkg: debug FSM/cause encodings and memory port types for the processor debug controller.
// Revision 1.0
package proc_dbg_pkg;
    typedef logic [11:0] Imem_addr;
    typedef logic [11:0] Dmem_addr;
    typedef logic [31:0] Imem_data;
    typedef logic [31:0] Dmem_data;

    localparam int IA_W = $bits(Imem_addr);
    localparam int DA_W = $bits(Dmem_addr);
    localparam int ID_W = $bits(Imem_data);
    localparam int DD_W = $bits(Dmem_data);

    typedef enum logic [1:0] {
        HALTED = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        RESUME = 2'd3
    } Dbg_state;

    typedef enum logic [1:0] {
        CAUSE_NONE  = 2'd0,
        CAUSE_HOLD  = 2'd1,
        CAUSE_BREAK = 2'd2
    } Break_cause;
endpackage
`default_nettype wire

// File: rtl/proc_debug_ctrl_if.sv
`default_nettype none
// Processor_if: JTAG debug master <-> processor debug controller link.
// Revision 1.0
interface Processor_if #(parameter int PC_W = 32);
    import proc_dbg_pkg::*;

    logic            en;
    logic            hold;
    logic            break_continue;
    Imem_addr        inst_break;
    logic            inst_break_en;
    logic            inst_break_pc_en;
    Dmem_addr        data_break;
    logic            data_break_wr_en;
    logic            data_break_rd_en;
    logic            imem_we;
    logic            imem_re;
    logic            dmem_we;
    logic            dmem_re;
    logic            doorbell;
    logic            clk_force_on;
    logic            clk_force_off;
    logic            break_status;
    logic            sleep_status;
    logic [PC_W-1:0] mon_pc;
    logic [31:0]     mon_inst;
    Imem_data        imem_data_r;
    Dmem_data        dmem_data_r;

    modport master (
        output en, hold, break_continue, inst_break, inst_break_en, inst_break_pc_en,
               data_break, data_break_wr_en, data_break_rd_en,
               imem_we, imem_re, dmem_we, dmem_re, doorbell, clk_force_on, clk_force_off,
        input  break_status, sleep_status, mon_pc, mon_inst, imem_data_r, dmem_data_r
    );

    modport proc (
        input  en, hold, break_continue, inst_break, inst_break_en, inst_break_pc_en,
               data_break, data_break_wr_en, data_break_rd_en,
               imem_we, imem_re, dmem_we, dmem_re, doorbell, clk_force_on, clk_force_off,
        output break_status, sleep_status, mon_pc, mon_inst, imem_data_r, dmem_data_r
    );
endinterface
`default_nettype wire

// File: rtl/proc_debug_ctrl_break_match.sv
`default_nettype none
// dbg_break_match: combinational instruction/data breakpoint comparators.
// Revision 1.0
module dbg_break_match
    import proc_dbg_pkg::*;
(
    input  logic [IA_W-1:0] inst_break_i,
    input  logic            inst_break_en_i,
    input  logic            inst_break_pc_en_i,
    input  logic [IA_W-1:0] fetch_pc_i,
    input  logic            fetch_valid_i,
    input  logic [IA_W-1:0] retire_pc_i,
    input  logic            retire_i,
    input  logic [DA_W-1:0] data_break_i,
    input  logic            data_break_wr_en_i,
    input  logic            data_break_rd_en_i,
    input  logic [DA_W-1:0] dmem_addr_i,
    input  logic            dmem_we_i,
    input  logic            dmem_re_i,
    output logic            hit_o
);
    logic w_inst_hit;
    logic w_data_hit;

    // Fetch-side match stops before execute; retire-side match stops after commit.
    assign w_inst_hit = inst_break_en_i &
                        (inst_break_pc_en_i ? (fetch_valid_i & (fetch_pc_i == inst_break_i))
                                            : (retire_i & (retire_pc_i == inst_break_i)));

    assign w_data_hit = ((dmem_we_i & data_break_wr_en_i) | (dmem_re_i & data_break_rd_en_i)) &
                        (dmem_addr_i == data_break_i);

    assign hit_o = w_inst_hit | w_data_hit;
endmodule
`default_nettype wire

// File: rtl/proc_debug_ctrl.sv
`default_nettype none
// proc_debug_ctrl: halt/resume FSM, breakpoints and debug memory gating. Optional clock gating
// under NUX_CLK_GATE_EN (otherwise core_clk_en_o is tied high). Revision 1.0
module proc_debug_ctrl
    import proc_dbg_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    Processor_if.proc        dbg,
    input  logic [PC_W-1:0]  core_pc_i,
    input  logic             core_pc_valid_i,
    input  logic             core_retire_i,
    input  logic [PC_W-1:0]  core_retire_pc_i,
    input  logic [31:0]      core_retire_inst_i,
    input  logic [DA_W-1:0]  core_dmem_addr_i,
    input  logic             core_dmem_we_i,
    input  logic             core_dmem_re_i,
    input  logic             core_quiet_i,
    input  logic             core_sleep_i,
    output logic             core_halt_o,
    output logic             core_irq_db_o,
    output logic             core_clk_en_o,
    output logic             mem_dbg_sel_o,
    output logic             mem_imem_we_o,
    output logic             mem_imem_re_o,
    output logic             mem_dmem_we_o,
    output logic             mem_dmem_re_o,
    input  logic [ID_W-1:0]  imem_q_i,
    input  logic [DD_W-1:0]  dmem_q_i
);
    Dbg_state   state_q, state_d;
    Break_cause cause_q, cause_d;
    logic       core_halt_q, mem_dbg_sel_q, break_status_q;
    logic       cont_prev_q, db_prev_q, irq_db_q, sleep_q;
    logic       imem_rd_q, dmem_rd_q;
    logic [ID_W-1:0] imem_data_q;
    logic [DD_W-1:0] dmem_data_q;
    logic [PC_W-1:0] mon_pc_q;
    logic [31:0]     mon_inst_q;
    logic w_match, w_hit, w_cont_rise, w_unused_pc_hi;

    dbg_break_match u_match (
        .inst_break_i       (dbg.inst_break),
        .inst_break_en_i    (dbg.inst_break_en),
        .inst_break_pc_en_i (dbg.inst_break_pc_en),
        .fetch_pc_i         (core_pc_i[IA_W-1:0]),
        .fetch_valid_i      (core_pc_valid_i),
        .retire_pc_i        (core_retire_pc_i[IA_W-1:0]),
        .retire_i           (core_retire_i),
        .data_break_i       (dbg.data_break),
        .data_break_wr_en_i (dbg.data_break_wr_en),
        .data_break_rd_en_i (dbg.data_break_rd_en),
        .dmem_addr_i        (core_dmem_addr_i),
        .dmem_we_i          (core_dmem_we_i),
        .dmem_re_i          (core_dmem_re_i),
        .hit_o              (w_match)
    );

    // Only RUN honours matches, which masks the RESUME cycle re-fetching the break address.
    assign w_hit          = w_match & (state_q == RUN);
    assign w_cont_rise    = dbg.break_continue & ~cont_prev_q;
    assign w_unused_pc_hi = ^core_pc_i[PC_W-1:IA_W];

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        case (state_q)
            HALTED: begin
                if (dbg.en && !dbg.hold && (cause_q != CAUSE_BREAK || w_cont_rise)) begin
                    state_d = RESUME;
                    cause_d = CAUSE_NONE;
                end
            end
            RESUME: begin
                if (!dbg.en) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_HOLD;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (w_hit) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_BREAK;
                end else if (!dbg.en || dbg.hold) begin
                    state_d = DRAIN;
                    cause_d = CAUSE_HOLD;
                end
            end
            DRAIN: begin
                if (core_quiet_i) state_d = HALTED;
            end
            default: begin
                state_d = HALTED;
                cause_d = CAUSE_NONE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= HALTED;
            cause_q        <= CAUSE_NONE;
            core_halt_q    <= 1'b1;
            mem_dbg_sel_q  <= 1'b1;
            break_status_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cause_q        <= cause_d;
            core_halt_q    <= (state_d != RUN);
            mem_dbg_sel_q  <= (state_d == HALTED);
            break_status_q <= ((state_d == DRAIN) || (state_d == HALTED)) && (cause_d == CAUSE_BREAK);
        end
    end

    assign mem_imem_we_o = dbg.imem_we & mem_dbg_sel_q;
    assign mem_imem_re_o = dbg.imem_re & mem_dbg_sel_q;
    assign mem_dmem_we_o = dbg.dmem_we & mem_dbg_sel_q;
    assign mem_dmem_re_o = dbg.dmem_re & mem_dbg_sel_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cont_prev_q <= 1'b0;
            db_prev_q   <= 1'b0;
            irq_db_q    <= 1'b0;
            sleep_q     <= 1'b0;
            imem_rd_q   <= 1'b0;
            dmem_rd_q   <= 1'b0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
            mon_pc_q    <= '0;
            mon_inst_q  <= '0;
        end else begin
            cont_prev_q <= dbg.break_continue;
            db_prev_q   <= dbg.doorbell;
            irq_db_q    <= dbg.doorbell & ~db_prev_q & (state_q != HALTED);
            sleep_q     <= core_sleep_i;
            imem_rd_q   <= mem_imem_re_o;
            dmem_rd_q   <= mem_dmem_re_o;
            if (imem_rd_q) imem_data_q <= imem_q_i;
            if (dmem_rd_q) dmem_data_q <= dmem_q_i;
            if (core_retire_i) begin
                mon_pc_q   <= core_retire_pc_i;
                mon_inst_q <= core_retire_inst_i;
            end
        end
    end

`ifdef NUX_CLK_GATE_EN
    // Clock is kept running through reset so the core can sample its own synchronous reset.
    assign core_clk_en_o = reset | dbg.clk_force_on |
                           (~dbg.clk_force_off & ~mem_dbg_sel_q & ~sleep_q);
`else
    logic w_unused_clk_force;
    assign w_unused_clk_force = dbg.clk_force_on ^ dbg.clk_force_off;
    assign core_clk_en_o      = 1'b1;
`endif

    assign core_halt_o      = core_halt_q;
    assign mem_dbg_sel_o    = mem_dbg_sel_q;
    assign core_irq_db_o    = irq_db_q;
    assign dbg.break_status = break_status_q;
    assign dbg.sleep_status = sleep_q;
    assign dbg.mon_pc       = mon_pc_q;
    assign dbg.mon_inst     = mon_inst_q;
    assign dbg.imem_data_r  = imem_data_q;
    assign dbg.dmem_data_r  = dmem_data_q;
endmodule
`default_nettype wire

// File: tb/tb_proc_debug_ctrl.sv
`default_nettype none
// tb_proc_debug_ctrl: directed self-checking bench for proc_debug_ctrl (either NUX_CLK_GATE_EN build).
// Revision 1.0
module tb_proc_debug_ctrl;
    import proc_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] core_pc, core_retire_pc, core_retire_inst;
    logic        core_pc_valid, core_retire;
    logic [DA_W-1:0] core_dmem_addr;
    logic        core_dmem_we, core_dmem_re, core_quiet, core_sleep;
    logic        core_halt, core_irq_db, core_clk_en, mem_dbg_sel;
    logic        mem_imem_we, mem_imem_re, mem_dmem_we, mem_dmem_re;
    logic [31:0] imem_q = 32'h0;
    logic [31:0] dmem_q = 32'h0;
    int          n_cmp = 0;
    int          n_fail = 0;
    logic        exp_clk;

    Processor_if #(.PC_W(32)) dbg ();

    proc_debug_ctrl #(.PC_W(32)) dut (
        .clk(clk), .reset(reset), .dbg(dbg),
        .core_pc_i(core_pc), .core_pc_valid_i(core_pc_valid), .core_retire_i(core_retire),
        .core_retire_pc_i(core_retire_pc), .core_retire_inst_i(core_retire_inst),
        .core_dmem_addr_i(core_dmem_addr), .core_dmem_we_i(core_dmem_we), .core_dmem_re_i(core_dmem_re),
        .core_quiet_i(core_quiet), .core_sleep_i(core_sleep),
        .core_halt_o(core_halt), .core_irq_db_o(core_irq_db), .core_clk_en_o(core_clk_en),
        .mem_dbg_sel_o(mem_dbg_sel), .mem_imem_we_o(mem_imem_we), .mem_imem_re_o(mem_imem_re),
        .mem_dmem_we_o(mem_dmem_we), .mem_dmem_re_o(mem_dmem_re),
        .imem_q_i(imem_q), .dmem_q_i(dmem_q)
    );

    always #5 clk = ~clk;

    // Synchronous memories: data only appears the cycle after an enabled read.
    always @(posedge clk) begin
        imem_q <= mem_imem_re ? 32'hDEAD_BEEF : 32'h0;
        dmem_q <= mem_dmem_re ? 32'h1234_5678 : 32'h0;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        step(2);
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL rst_halt: got %b want 1", core_halt); end
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL rst_sel: got %b want 1", mem_dbg_sel); end
        n_cmp++; if (dbg.break_status !== 1'b0) begin n_fail++; $display("FAIL rst_brk: got %b want 0", dbg.break_status); end
        n_cmp++; if (core_irq_db !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", core_irq_db); end
        n_cmp++; if (dbg.mon_pc !== 32'h0) begin n_fail++; $display("FAIL rst_monpc: got %h want 0", dbg.mon_pc); end
        n_cmp++; if (dbg.imem_data_r !== 32'h0) begin n_fail++; $display("FAIL rst_idata: got %h want 0", dbg.imem_data_r); end
        n_cmp++; if (core_clk_en !== 1'b1) begin n_fail++; $display("FAIL rst_clken: got %b want 1", core_clk_en); end
        reset = 1'b0;
        step(1);
`ifdef NUX_CLK_GATE_EN
        exp_clk = 1'b0;
`else
        exp_clk = 1'b1;
`endif
        n_cmp++; if (core_clk_en !== exp_clk) begin n_fail++; $display("FAIL halted_clken: got %b want %b", core_clk_en, exp_clk); end
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL idle_sel: got %b want 1", mem_dbg_sel); end
    endtask

    task automatic test_run_start;
        dbg.en = 1'b1;
        step(1);
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL resume_halt: got %b want 1", core_halt); end
        n_cmp++; if (mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL resume_sel: got %b want 0", mem_dbg_sel); end
        step(1);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL run_halt: got %b want 0", core_halt); end
    endtask

    task automatic test_hold;
        dbg.hold = 1'b1;
        step(1);
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL drain_halt: got %b want 1", core_halt); end
        step(3);
        n_cmp++; if (mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL drain_wait_sel: got %b want 0", mem_dbg_sel); end
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL hold_halted_sel: got %b want 1", mem_dbg_sel); end
        n_cmp++; if (dbg.break_status !== 1'b0) begin n_fail++; $display("FAIL hold_brk: got %b want 0", dbg.break_status); end
        dbg.hold = 1'b0;
        step(1);
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL hold_resume_halt: got %b want 1", core_halt); end
        step(1);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL hold_run_halt: got %b want 0", core_halt); end
    endtask

    task automatic test_mem_gate;
        dbg.imem_re = 1'b1;
        #1;
        n_cmp++; if (mem_imem_re !== 1'b0) begin n_fail++; $display("FAIL run_imem_re: got %b want 0", mem_imem_re); end
        step(2);
        dbg.imem_re = 1'b0;
        n_cmp++; if (dbg.imem_data_r !== 32'h0) begin n_fail++; $display("FAIL run_idata: got %h want 0", dbg.imem_data_r); end
        dbg.hold = 1'b1;
        step(1);
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        dbg.imem_re = 1'b1;
        dbg.dmem_we = 1'b1;
        #1;
        n_cmp++; if (mem_imem_re !== 1'b1) begin n_fail++; $display("FAIL halt_imem_re: got %b want 1", mem_imem_re); end
        n_cmp++; if (mem_dmem_we !== 1'b1) begin n_fail++; $display("FAIL halt_dmem_we: got %b want 1", mem_dmem_we); end
        step(1);
        dbg.imem_re = 1'b0;
        dbg.dmem_we = 1'b0;
        n_cmp++; if (dbg.imem_data_r !== 32'h0) begin n_fail++; $display("FAIL idata_early: got %h want 0", dbg.imem_data_r); end
        step(1);
        n_cmp++; if (dbg.imem_data_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idata_lat2: got %h want deadbeef", dbg.imem_data_r); end
        step(1);
        n_cmp++; if (dbg.imem_data_r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL idata_hold: got %h want deadbeef", dbg.imem_data_r); end
        dbg.hold = 1'b0;
        step(2);
    endtask

    task automatic test_inst_break;
        dbg.inst_break = 12'h040;
        dbg.inst_break_en = 1'b1;
        dbg.inst_break_pc_en = 1'b1;
        core_pc = 32'h40;
        core_pc_valid = 1'b1;
        step(1);
        core_pc_valid = 1'b0;
        n_cmp++; if (dbg.break_status !== 1'b1) begin n_fail++; $display("FAIL ibrk_drain_brk: got %b want 1", dbg.break_status); end
        n_cmp++; if (core_halt !== 1'b1) begin n_fail++; $display("FAIL ibrk_halt: got %b want 1", core_halt); end
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        n_cmp++; if (dbg.break_status !== 1'b1) begin n_fail++; $display("FAIL ibrk_halted_brk: got %b want 1", dbg.break_status); end
        step(2);
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL ibrk_stays_halted: got %b want 1", mem_dbg_sel); end
        core_pc_valid = 1'b1;
        dbg.break_continue = 1'b1;
        step(1);
        n_cmp++; if (mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL cont_resume_sel: got %b want 0", mem_dbg_sel); end
        n_cmp++; if (dbg.break_status !== 1'b0) begin n_fail++; $display("FAIL cont_brk_clear: got %b want 0", dbg.break_status); end
        core_pc = 32'h44;
        step(1);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL cont_run: got %b want 0", core_halt); end
        step(2);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL cont_no_rehit: got %b want 0", core_halt); end
        // Retire-side breakpoint: a fetch of the address must not stop the core.
        dbg.inst_break = 12'h080;
        dbg.inst_break_pc_en = 1'b0;
        core_pc = 32'h80;
        step(1);
        core_pc_valid = 1'b0;
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL retire_fetch_nohit: got %b want 0", core_halt); end
        core_retire = 1'b1;
        core_retire_pc = 32'h80;
        core_retire_inst = 32'h0010_0073;
        step(1);
        core_retire = 1'b0;
        n_cmp++; if (dbg.break_status !== 1'b1) begin n_fail++; $display("FAIL retire_brk: got %b want 1", dbg.break_status); end
        n_cmp++; if (dbg.mon_pc !== 32'h80) begin n_fail++; $display("FAIL mon_pc: got %h want 80", dbg.mon_pc); end
        n_cmp++; if (dbg.mon_inst !== 32'h0010_0073) begin n_fail++; $display("FAIL mon_inst: got %h want 00100073", dbg.mon_inst); end
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        dbg.break_continue = 1'b0;
        step(1);
        dbg.break_continue = 1'b1;
        step(2);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL retire_cont_run: got %b want 0", core_halt); end
        dbg.inst_break_en = 1'b0;
    endtask

    task automatic test_data_break;
        dbg.data_break = 12'h010;
        dbg.data_break_wr_en = 1'b1;
        core_dmem_addr = 12'h010;
        core_dmem_re = 1'b1;
        step(1);
        core_dmem_re = 1'b0;
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL dbrk_read_nohit: got %b want 0", core_halt); end
        core_dmem_we = 1'b1;
        dbg.hold = 1'b1;
        step(1);
        core_dmem_we = 1'b0;
        dbg.hold = 1'b0;
        n_cmp++; if (dbg.break_status !== 1'b1) begin n_fail++; $display("FAIL dbrk_hold_prio: got %b want 1", dbg.break_status); end
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        dbg.break_continue = 1'b0;
        n_cmp++; if (dbg.break_status !== 1'b1) begin n_fail++; $display("FAIL dbrk_halted_brk: got %b want 1", dbg.break_status); end
        step(1);
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL dbrk_stays_halted: got %b want 1", mem_dbg_sel); end
        dbg.break_continue = 1'b1;
        step(2);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL dbrk_cont_run: got %b want 0", core_halt); end
        dbg.data_break_wr_en = 1'b0;
    endtask

    task automatic test_sleep_doorbell;
        core_sleep = 1'b1;
        step(1);
        core_sleep = 1'b0;
`ifdef NUX_CLK_GATE_EN
        exp_clk = 1'b0;
`else
        exp_clk = 1'b1;
`endif
        n_cmp++; if (dbg.sleep_status !== 1'b1) begin n_fail++; $display("FAIL sleep_status: got %b want 1", dbg.sleep_status); end
        n_cmp++; if (core_clk_en !== exp_clk) begin n_fail++; $display("FAIL sleep_clken: got %b want %b", core_clk_en, exp_clk); end
        dbg.doorbell = 1'b1;
        step(1);
        n_cmp++; if (core_irq_db !== 1'b1) begin n_fail++; $display("FAIL db_pulse: got %b want 1", core_irq_db); end
        step(1);
        n_cmp++; if (core_irq_db !== 1'b0) begin n_fail++; $display("FAIL db_one_cycle: got %b want 0", core_irq_db); end
        dbg.doorbell = 1'b0;
        dbg.hold = 1'b1;
        step(1);
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        dbg.doorbell = 1'b1;
        step(1);
        n_cmp++; if (core_irq_db !== 1'b0) begin n_fail++; $display("FAIL db_halted: got %b want 0", core_irq_db); end
        dbg.hold = 1'b0;
        step(1);
        n_cmp++; if (core_irq_db !== 1'b0) begin n_fail++; $display("FAIL db_not_queued1: got %b want 0", core_irq_db); end
        step(1);
        n_cmp++; if (core_irq_db !== 1'b0) begin n_fail++; $display("FAIL db_not_queued2: got %b want 0", core_irq_db); end
        dbg.doorbell = 1'b0;
    endtask

    task automatic test_clk_gate;
        dbg.hold = 1'b1;
        step(1);
        core_quiet = 1'b1;
        step(1);
        core_quiet = 1'b0;
        dbg.clk_force_off = 1'b1;
        #1;
`ifdef NUX_CLK_GATE_EN
        dbg.clk_force_off = 1'b0;
        #1;
        n_cmp++; if (core_clk_en !== 1'b0) begin n_fail++; $display("FAIL cg_halted: got %b want 0", core_clk_en); end
        dbg.clk_force_on = 1'b1;
        #1;
        n_cmp++; if (core_clk_en !== 1'b1) begin n_fail++; $display("FAIL cg_force_on: got %b want 1", core_clk_en); end
        dbg.clk_force_off = 1'b1;
        #1;
        n_cmp++; if (core_clk_en !== 1'b1) begin n_fail++; $display("FAIL cg_both: got %b want 1", core_clk_en); end
        dbg.clk_force_on = 1'b0;
        #1;
        n_cmp++; if (core_clk_en !== 1'b0) begin n_fail++; $display("FAIL cg_force_off: got %b want 0", core_clk_en); end
`else
        n_cmp++; if (core_clk_en !== 1'b1) begin n_fail++; $display("FAIL cg_tied: got %b want 1", core_clk_en); end
`endif
        dbg.clk_force_on = 1'b0;
        dbg.clk_force_off = 1'b0;
        dbg.hold = 1'b0;
        step(2);
    endtask

    task automatic test_en_drop_reset;
        dbg.en = 1'b0;
        step(1);
        n_cmp++; if (core_halt !== 1'b1 || mem_dbg_sel !== 1'b0) begin n_fail++; $display("FAIL en_drop_drain: got halt=%b sel=%b want 1/0", core_halt, mem_dbg_sel); end
        core_quiet = 1'b1;
        step(3);
        core_quiet = 1'b0;
        n_cmp++; if (mem_dbg_sel !== 1'b1) begin n_fail++; $display("FAIL en_off_halted: got %b want 1", mem_dbg_sel); end
        dbg.en = 1'b1;
        step(2);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL en_back_run: got %b want 0", core_halt); end
        dbg.hold = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        dbg.hold = 1'b0;
        n_cmp++; if (mem_dbg_sel !== 1'b1 || dbg.break_status !== 1'b0) begin n_fail++; $display("FAIL rst_mid_drain: got sel=%b brk=%b want 1/0", mem_dbg_sel, dbg.break_status); end
        step(2);
        n_cmp++; if (core_halt !== 1'b0) begin n_fail++; $display("FAIL rst_then_run: got %b want 0", core_halt); end
    endtask

    initial begin
        reset = 1'b1;
        core_pc = '0; core_pc_valid = 1'b0; core_retire = 1'b0;
        core_retire_pc = '0; core_retire_inst = '0;
        core_dmem_addr = '0; core_dmem_we = 1'b0; core_dmem_re = 1'b0;
        core_quiet = 1'b0; core_sleep = 1'b0;
        dbg.en = 1'b0; dbg.hold = 1'b0; dbg.break_continue = 1'b0;
        dbg.inst_break = '0; dbg.inst_break_en = 1'b0; dbg.inst_break_pc_en = 1'b0;
        dbg.data_break = '0; dbg.data_break_wr_en = 1'b0; dbg.data_break_rd_en = 1'b0;
        dbg.imem_we = 1'b0; dbg.imem_re = 1'b0; dbg.dmem_we = 1'b0; dbg.dmem_re = 1'b0;
        dbg.doorbell = 1'b0; dbg.clk_force_on = 1'b0; dbg.clk_force_off = 1'b0;

        test_reset();
        test_run_start();
        test_hold();
        test_mem_gate();
        test_inst_break();
        test_data_break();
        test_sleep_doorbell();
        test_clk_gate();
        test_en_drop_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
